// File: rtl/ea_calc.sv
// ea_calc: resolves effective address E (Y + index, indirect chains via memory); optional EA_INDIRECT_LIMIT_EN bounds chain depth.
// Latency: 2 cycles accept-to-out_valid for direct/indexed, plus (1 + memory wait) per indirect level.
// Backpressure: holds out_inst/out_e and deasserts inst_ready until out_ready; mem_read held until mem_ack.
module ea_calc #(
    parameter int MAX_INDIRECT = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inst_valid,
    output logic         inst_ready,
    input  logic [0:35]  inst,
    output logic [0:3]   ac_addr,
    input  logic [0:35]  ac_data,
    output logic         mem_read,
    output logic [18:35] mem_addr,
    input  logic         mem_ack,
    input  logic [0:35]  mem_data,
    input  logic         interrupt_pending,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:35]  out_inst,
    output logic [18:35] out_e,
    output logic         ea_abort,
    output logic         ea_fault
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] IND  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]   state;
    logic         w_i;
    logic [0:3]   w_x;
    logic [18:35] w_y;
    logic [18:35] e_sum;
    logic         ind_limit;
    logic         unused_bits;

    // X=0 means "no index", never AC0.
    assign e_sum = w_y + ((w_x != 4'd0) ? ac_data[18:35] : 18'd0);

    assign inst_ready = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign mem_read   = (state == IND);
    assign mem_addr   = out_e;
    assign ac_addr    = w_x;

    assign unused_bits = ^{ac_data[0:17], mem_data[0:12]};

`ifdef EA_INDIRECT_LIMIT_EN
    localparam int CW = $clog2(MAX_INDIRECT + 1) + 1;

    logic [CW-1:0] ind_cnt;

    // Counter already equals the limit: one more level would exceed it.
    assign ind_limit = (ind_cnt >= CW'(MAX_INDIRECT));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ind_cnt  <= '0;
            ea_fault <= 1'b0;
        end else begin
            ea_fault <= (state == CALC) && w_i && !interrupt_pending && ind_limit;
            if (state == IDLE && inst_valid) begin
                ind_cnt <= '0;
            end else if (state == CALC && w_i && !interrupt_pending && !ind_limit) begin
                ind_cnt <= ind_cnt + 1'b1;
            end
        end
    end
`else
    localparam int unused_max_indirect = MAX_INDIRECT;

    assign ind_limit = 1'b0;
    assign ea_fault  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            w_i      <= 1'b0;
            w_x      <= '0;
            w_y      <= '0;
            out_inst <= '0;
            out_e    <= '0;
            ea_abort <= 1'b0;
        end else begin
            ea_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_valid) begin
                        out_inst <= inst;
                        w_i      <= inst[13];
                        w_x      <= inst[14:17];
                        w_y      <= inst[18:35];
                        state    <= CALC;
                    end
                end
                CALC: begin
                    out_e <= e_sum;
                    if (!w_i) begin
                        state <= DONE;
                    end else if (interrupt_pending) begin
                        // Abort wins over the depth limit when both hold.
                        ea_abort <= 1'b1;
                        state    <= IDLE;
                    end else if (ind_limit) begin
                        state <= IDLE;
                    end else begin
                        state <= IND;
                    end
                end
                IND: begin
                    if (mem_ack) begin
                        w_i   <= mem_data[13];
                        w_x   <= mem_data[14:17];
                        w_y   <= mem_data[18:35];
                        state <= CALC;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ea_calc.sv
// Bench for ea_calc: vector table for direct/indexed forms, hand sequences for indirect, abort, reset and limit cases.
module tb_ea_calc;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         inst_valid;
    logic         inst_ready;
    logic [0:35]  inst;
    logic [0:3]   ac_addr;
    logic [0:35]  ac_data;
    logic         mem_read;
    logic [18:35] mem_addr;
    logic         mem_ack;
    logic [0:35]  mem_data;
    logic         interrupt_pending;
    logic         out_valid;
    logic         out_ready;
    logic [0:35]  out_inst;
    logic [18:35] out_e;
    logic         ea_abort;
    logic         ea_fault;

    typedef struct {
        logic [0:35]  ins;
        logic [18:35] ea;
    } exp_t;

    typedef struct {
        logic [0:35]  ins;
        logic [0:3]   ac_idx;
        logic [0:35]  ac_val;
        logic [18:35] exp_e;
        int           hold;
    } vec_t;

    exp_t         sb_q[$];
    logic [18:35] addr_log[$];
    logic [0:35]  ac_regs [16];
    logic [0:35]  mem_arr [512];
    int           checks = 0;
    int           errors = 0;
    int           ind_cycles = 0;
    int           ack_delay = 1;
    int           fault_pulses = 0;
    logic         force_ack;
    vec_t         vecs [5];

    always #5 clk = ~clk;

    ea_calc #(.MAX_INDIRECT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .ac_addr(ac_addr), .ac_data(ac_data),
        .mem_read(mem_read), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .interrupt_pending(interrupt_pending),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_e(out_e),
        .ea_abort(ea_abort), .ea_fault(ea_fault)
    );

    assign ac_data  = ac_regs[ac_addr];
    assign mem_data = mem_arr[mem_addr[27:35]];
    assign mem_ack  = force_ack | (mem_read && (ind_cycles == ack_delay - 1));

    // Memory wait counter: number of IND cycles already spent on the current read.
    always @(posedge clk) begin
        if (mem_read && !mem_ack) ind_cycles <= ind_cycles + 1;
        else                      ind_cycles <= 0;
    end

    always @(negedge clk) begin
        if (mem_read && mem_ack) addr_log.push_back(mem_addr);
        if (ea_fault) fault_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", nm, act, exp);
        end
    endtask

    task automatic send(input logic [0:35] ins, input logic [18:35] e, input int exp_lat,
                        input int hold, input logic exp_rd);
        int   lat;
        logic found;
        logic rd_seen;
        logic [0:3] x;
        exp_t sb;
        x = ins[14:17];
        inst = ins;
        inst_valid = 1'b1;
        sb_q.push_back('{ins: ins, ea: e});
        @(posedge clk); #1;
        inst_valid = 1'b0;
        inst = '0;
        lat = 0;
        found = 1'b0;
        rd_seen = 1'b0;
        while (!found && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && x != 4'd0) chk("ac_addr in CALC", ac_addr, x);
            if (mem_read) rd_seen = 1'b1;
            if (out_valid) found = 1'b1;
        end
        chk("out_valid latency", found ? lat : 0, exp_lat);
        chk("mem_read activity", rd_seen, exp_rd);
        if (found) begin
            sb = sb_q.pop_front();
            chk("out_inst", out_inst, sb.ins);
            chk("out_e", out_e, sb.ea);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("backpressure hold", {out_valid, inst_ready, out_inst, out_e}, {1'b1, 1'b0, sb.ins, sb.ea});
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle after consume", {inst_ready, out_valid}, 2'b10);
    endtask

    initial begin
        int   n;
        logic seen;
        logic ov;

        vecs[0] = '{36'o200040001234, 4'd1,  36'o000000000000, 18'o001234, 0};
        vecs[1] = '{36'o200043777770, 4'd3,  36'o123456000020, 18'o000010, 5};
        vecs[2] = '{36'o200045001000, 4'd5,  36'o000000000777, 18'o001777, 0};
        vecs[3] = '{36'o200040000007, 4'd0,  36'o000000000100, 18'o000007, 0};
        vecs[4] = '{36'o200057000000, 4'd15, 36'o777777777777, 18'o777777, 2};

        for (int i = 0; i < 16; i++) ac_regs[i] = '0;
        for (int i = 0; i < 512; i++) mem_arr[i] = '0;
        reset_n = 1'b0;
        inst_valid = 1'b0;
        inst = '0;
        out_ready = 1'b0;
        interrupt_pending = 1'b0;
        force_ack = 1'b0;

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset handshake", {inst_ready, out_valid, mem_read}, 3'b100);
        chk("reset pulses", {ea_abort, ea_fault}, 2'b00);
        chk("reset out_inst", out_inst, 36'o0);
        chk("reset out_e/mem_addr", {out_e, mem_addr}, 36'o0);

        for (int v = 0; v < 5; v++) begin
            ac_regs[vecs[v].ac_idx] = vecs[v].ac_val;
            send(vecs[v].ins, vecs[v].exp_e, 2, vecs[v].hold, 1'b0);
        end

        // Two-level indirect with a 2-cycle memory wait; junk in ignored high bits.
        ac_regs[2] = 36'o000000000005;
        mem_arr[9'o100] = 36'o777022000200;
        mem_arr[9'o205] = 36'o123000000300;
        ack_delay = 2;
        addr_log.delete();
        send(36'o200060000100, 18'o000300, 8, 0, 1'b1);
        chk("indirect read count", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            chk("first mem_addr", addr_log[0], 18'o000100);
            chk("second mem_addr", addr_log[1], 18'o000205);
        end

        // Self-referencing chain broken by interrupt.
        mem_arr[9'o100] = 36'o000020000100;
        ack_delay = 1;
        inst = 36'o200060000100;
        inst_valid = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 interrupt_pending = 1'b1;
        seen = 1'b0;
        ov = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            if (out_valid) ov = 1'b1;
            if (ea_abort) seen = 1'b1;
        end
        chk("ea_abort pulse", seen, 1'b1);
        chk("idle during abort pulse", {inst_ready, mem_read, out_valid}, 3'b100);
        interrupt_pending = 1'b0;
        @(negedge clk);
        chk("ea_abort one cycle", ea_abort, 1'b0);
        chk("no out_valid on abort", ov | out_valid, 1'b0);

        // Reset while a read is outstanding, then a stray ack in IDLE.
        ack_delay = 1000;
        inst = 36'o200060000100;
        inst_valid = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        n = 0;
        while (!mem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mem_read before reset", mem_read, 1'b1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("after reset in IND", {mem_read, inst_ready, out_valid, out_e}, {1'b0, 1'b1, 1'b0, 18'o0});
        force_ack = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(negedge clk);
        chk("late mem_ack ignored", {mem_read, inst_ready, out_valid}, 3'b010);
        ack_delay = 1;
        send(36'o200040000777, 18'o000777, 2, 0, 1'b0);

`ifdef EA_INDIRECT_LIMIT_EN
        addr_log.delete();
        inst = 36'o200060000100;
        inst_valid = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (ea_fault) seen = 1'b1;
        end
        chk("ea_fault raised", seen, 1'b1);
        chk("reads before fault", addr_log.size(), 4);
        chk("idle during fault pulse", {inst_ready, out_valid, mem_read}, 3'b100);
        @(negedge clk);
        chk("ea_fault one cycle", ea_fault, 1'b0);
`else
        chk("no ea_fault without limit", fault_pulses, 0);
`endif

        chk("scoreboard drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ea_calc.md
# ea_calc

Effective-address calculation stage between instruction fetch and the instruction decode ROM / main state machine. Accepts a fetched 36-bit instruction, resolves E from the Y, X (index) and I (indirect) fields, and follows indirect chains through memory. Presents the original instruction plus the final 18-bit E to the decode/dispatch stage over a valid/ready handshake.

## Interface

- `MAX_INDIRECT`, default 16: indirect-level limit; only used when `EA_INDIRECT_LIMIT_EN` is defined.
- `clk` in 1: system clock; all state changes on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `inst_valid` in 1: fetch stage offers `inst`.
- `inst_ready` out 1: stage can accept an instruction.
- `inst` in [0:35]: instruction word. Field layout: op [0:8], AC [9:12], I [13], X [14:17], Y [18:35].
- `ac_addr` out [0:3]: register-file read address (index register).
- `ac_data` in [0:35]: register-file data; combinational, valid in the same cycle as `ac_addr`.
- `mem_read` out 1: indirect-word read request; held until `mem_ack`.
- `mem_addr` out [18:35]: read address.
- `mem_ack` in 1: read complete; `mem_data` valid this cycle.
- `mem_data` in [0:35]: indirect word.
- `interrupt_pending` in 1: request to break an indirect chain.
- `out_valid` out 1: `out_inst`/`out_e` valid.
- `out_ready` in 1: downstream consumes.
- `out_inst` out [0:35]: instruction exactly as accepted.
- `out_e` out [18:35]: effective address E.
- `ea_abort` out 1: one-cycle pulse, chain abandoned for interrupt.
- `ea_fault` out 1: one-cycle pulse, indirect limit exceeded (tied 0 without the macro).

## Operation

- States: IDLE, CALC, IND, DONE.
- IDLE: `inst_ready`=1. On `inst_valid`, latch `inst` into `out_inst` and into working fields wI, wX, wY. Next state is CALC.
- CALC: `ac_addr`=wX. Compute E = wY + (wX≠0 ? `ac_data`[18:35] : 0), mod 2^18 (carry discarded). Register E into `out_e`.
  - If wI=0, the next state is DONE.
  - If wI=1 and `interrupt_pending`=1, pulse `ea_abort` and return to IDLE. No output is produced.
  - If wI=1 and the limit is exceeded (macro only), pulse `ea_fault` and return to IDLE.
  - Otherwise the next state is IND.
- IND: `mem_read`=1 and `mem_addr`=`out_e`, both held steady until `mem_ack`.
  - On `mem_ack`, load wI=`mem_data`[13], wX=`mem_data`[14:17], wY=`mem_data`[18:35]; next state is CALC.
  - `mem_data`[0:12] is ignored.
  - `interrupt_pending` is not sampled in IND.
- DONE: `out_valid`=1 with outputs stable until `out_ready`. On `out_ready`, the next state is IDLE.
- X=0 never reads AC0 as an index; `ac_addr` is a don't-care in that case.
- `ac_addr` outside CALC is a don't-care.

## Timing

- Reset (`reset_n`=0 at an edge):
  - State goes to IDLE and the indirect counter clears.
  - `out_valid`, `mem_read`, `ea_abort`, `ea_fault` are 0 from the next cycle.
  - `out_inst`, `out_e`, `mem_addr` are 0.
  - Reset during IND drops `mem_read` immediately. A late `mem_ack` arriving in IDLE is ignored.
- Direct or indexed instruction: accepted at edge 0, CALC in cycle 1, `out_valid` in cycle 2.
- Each indirect level adds 1 (CALC) + N cycles, where N is the number of IND cycles up to and including `mem_ack`.
- `inst_ready` is asserted only in IDLE. Throughput is at most one instruction per 3 cycles.
- `mem_ack` outside IND is ignored.
- Pulses `ea_abort` and `ea_fault` are high for exactly the cycle after the CALC that raised them. In that cycle the state is already IDLE and `inst_ready`=1.
- `interrupt_pending` and the limit condition true in the same CALC: abort takes priority over fault.

## Configuration

- `EA_INDIRECT_LIMIT_EN`
- Defined:
  - An indirect counter clears on accept and increments on each CALC→IND transition.
  - A CALC that would make the counter exceed `MAX_INDIRECT` raises `ea_fault` and returns to IDLE.
- Undefined:
  - No counter exists and `ea_fault`=0.
  - Chains run unbounded; only `interrupt_pending` breaks them.

## Test plan

- Direct: `inst`=o200040001234 (MOVE 1,1234; I=0, X=0) → in cycle 2, `out_valid`=1, `out_e`=o001234, `out_inst` unchanged. No `mem_read`.
- Indexed wrap: Y=o777770, X=3, AC3 right half=o000020 → `out_e`=o000010. `ac_addr`=3 during CALC.
- Two-level indirect: Y=o100, I=1. C(100)=I=1, X=2, Y=o200, with AC2=o5. C(205)=I=0, Y=o300. Memory ack delay 2 cycles.
  - Required: `mem_addr` o100, then o205.
  - `out_e`=o300.
  - `out_valid` at cycle 2+(1+2)+(1+2)=8.
- Backpressure: hold `out_ready`=0 for 5 cycles → outputs stable and `inst_ready`=0 throughout. Release → IDLE the next cycle.
- Abort: self-referencing indirect word at o100 (I=1, Y=o100), then assert `interrupt_pending`.
  - Required: `ea_abort` one-cycle pulse, no `out_valid`, stage returns to IDLE.
- Reset during IND while `mem_read`=1 → `mem_read`=0 on the next cycle, state IDLE. A following `mem_ack` has no effect.
  - With `EA_INDIRECT_LIMIT_EN` and `MAX_INDIRECT`=4, the self-loop must raise `ea_fault` after exactly 4 reads.
